tlut_mul_sched: RTL and testbench
=================================

// Module: tlut_mul_sched
// PURPOSE
//  Job sequencer for the temporal-LUT matrix multiplier. Accepts multiply jobs over valid/ready,
//  starts TLUT product generation, waits for the products plus the registered adder-tree latency,
//  captures the reduced matrix into a result register and presents it over valid/ready.
//  Sits between the job front-end and the tlut product array / adder tree pair.
// PARAMETERS
//  ID_W      4    job tag width
//  RES_W     144  result bus width (DIM_ROW1*DIM_COL2*ACC_WIDTH)
//  TREE_LAT  1    adder-tree register stages between stable products and valid mult (>=1)
//  TMO_CYC   255  max cycles waiting for tlut_done before abort (>=1)
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      asynchronous reset, active-high
//  job_valid  in   1      job request
//  job_ready  out  1      job accepted when job_valid&&job_ready
//  job_id     in   ID_W   job tag
//  tlut_start out  1      one-cycle pulse starting TLUT product generation
//  tlut_done  in   1      products stable at adder-tree input (level or pulse)
//  mult_in    in   RES_W  adder-tree output
//  res_valid  out  1      result available
//  res_ready  in   1      consumer accepts result
//  res_id     out  ID_W   tag of presented result
//  res_data   out  RES_W  captured result
//  res_err    out  1      1 = job aborted by timeout, res_data all zero
// BEHAVIOUR
//  Reset: state IDLE; job_ready=1 (comb from IDLE), tlut_start=0, res_valid=0, res_id=0, res_data=0, res_err=0.
//  FSM states IDLE, RUN, SETTLE, OUT:
//   IDLE: job_ready=1; on accept latch job_id, tlut_start=1 next cycle, -> RUN, timer=TMO_CYC.
//   RUN: tlut_done sampled from first RUN cycle (done coincident with tlut_start pulse cycle ignored).
//        tlut_done=1 -> SETTLE, timer=TREE_LAT. timer reaches 0 without done -> OUT with res_err=1, res_data=0.
//   SETTLE: decrement timer each cycle; at 0 capture mult_in -> res_data, res_err=0, -> OUT.
//        Capture occurs exactly TREE_LAT+1 cycles after the cycle tlut_done was seen.
//   OUT: res_valid=1, res_data/res_id/res_err stable until handshake.
//        res_valid&&res_ready: if job_valid same cycle, job_ready=1 (comb) and job accepted -> RUN
//        with tlut_start pulse next cycle (back-to-back, no IDLE bubble); else -> IDLE.
//  job_ready=0 in RUN, SETTLE, and in OUT while res_ready=0.
//  tlut_start is registered, high exactly one cycle per accepted job.
//  Timer is TMO_CYC-wide down counter, saturates at 0, no wrap.
//  tlut_done in IDLE/SETTLE/OUT ignored. mult_in sampled only at capture.
//  rst asserted mid-job: immediate return to reset values; in-flight job dropped, no result.
// CONFIGURATION
//  TLUT_SCHED_PERF_EN defined: extra outputs perf_jobs[31:0] (count of completed result handshakes,
//   error jobs included) and perf_stall[31:0] (cycles in OUT with res_ready=0); both reset to 0,
//   wrap at 2^32. Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package tlut_sched_pkg: typedef enum logic[1:0] sched_state_t {IDLE,RUN,SETTLE,OUT};
//   localparam PERF_W=32; timer width function clog2(TMO_CYC+1).
//  One sub-module: tlut_sched_timer (load/decrement/zero-flag down counter), shared by RUN timeout
//   and SETTLE latency.
// TESTING
//  Single job id=3, tlut_done 5 cycles after start, TREE_LAT=1, mult_in=0x...A5 -> tlut_start one
//   pulse, capture 2 cycles after done, res_valid with res_id=3, res_data=0x...A5, res_err=0.
//  res_ready held low 10 cycles -> res_valid/res_data stable, job_ready=0; (PERF) perf_stall=10.
//  Back-to-back: job_valid high with ids 1,2; res_ready=1 -> job 2 accepted in res handshake cycle,
//   tlut_start for job 2 the following cycle, no IDLE cycle.
//  tlut_done never asserted, TMO_CYC=8 -> res_valid after 8 RUN cycles, res_err=1, res_data=0.
//  tlut_done asserted in tlut_start cycle only -> ignored, job times out with res_err=1.
//  rst pulsed during SETTLE -> all outputs 0 next edge, job_ready=1, no res_valid for that job.

Source files
------------

// File: rtl/tlut_sched_pkg.sv
// Shared types and constants for the temporal-LUT multiply job sequencer.
//   sched_state_t : sequencer FSM states
//   PERF_W        : width of the optional performance counters
//   timer_w()     : width of the shared down counter. It must hold both the
//                   timeout and the adder-tree latency.
package tlut_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    OUT    = 2'd3
  } sched_state_t;

  localparam int unsigned PERF_W = 32;

  function automatic int unsigned timer_w(input int unsigned tmo_cyc,
                                          input int unsigned tree_lat);
    int unsigned m;
    m = (tmo_cyc > tree_lat) ? tmo_cyc : tree_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tlut_sched_timer.sv
// Loadable down counter that saturates at zero. The sequencer uses it for the
// tlut_done timeout and for the adder-tree settle latency.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, holding at zero
//   cnt       : current count
//   zero      : count == 0
module tlut_sched_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tlut_mul_sched.sv
// Job sequencer for the temporal-LUT matrix multiplier. It does the following:
//   - accepts a job over valid/ready
//   - pulses tlut_start
//   - waits for tlut_done, then for the adder-tree latency
//   - captures mult_in and presents the result over valid/ready
// A timeout with no tlut_done returns an error result with zero data.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   job_valid/ready/id    : job request handshake and tag
//   tlut_start            : one-cycle registered start pulse per accepted job
//   tlut_done             : products stable at the adder-tree input
//   mult_in               : adder-tree output, sampled only at capture
//   res_valid/ready       : result handshake
//   res_id/data/err       : result tag, captured data, timeout flag
//   perf_jobs, perf_stall : only when TLUT_SCHED_PERF_EN is defined
// Configuration macro: TLUT_SCHED_PERF_EN (adds the performance counters).
module tlut_mul_sched
  import tlut_sched_pkg::*;
#(
  parameter int unsigned ID_W     = 4,
  parameter int unsigned RES_W    = 144,
  parameter int unsigned TREE_LAT = 1,
  parameter int unsigned TMO_CYC  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [ID_W-1:0]  job_id,
  output logic             tlut_start,
  input  logic             tlut_done,
  input  logic [RES_W-1:0] mult_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ID_W-1:0]  res_id,
  output logic [RES_W-1:0] res_data,
  output logic             res_err
`ifdef TLUT_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_jobs,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  localparam int unsigned TMR_W = timer_w(TMO_CYC, TREE_LAT);

  sched_state_t     state_q, state_d;
  logic [ID_W-1:0]  job_id_q, job_id_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [RES_W-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic             start_q, start_d;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val, tmr_cnt;

  tlut_sched_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    job_id_d   = job_id_q;
    res_id_d   = res_id_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    start_d    = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;
    job_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          job_id_d = job_id;
          start_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TMO_CYC);
          state_d  = RUN;
        end
      end
      RUN: begin
        tmr_dec = 1'b1;
        // A done level coincident with our own start pulse belongs to no job yet.
        if (tlut_done && !start_q) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TREE_LAT);
          state_d  = SETTLE;
        end else if (tmr_cnt <= TMR_W'(1)) begin
          // This cycle's decrement reaches zero, so RUN lasts exactly TMO_CYC cycles.
          res_id_d   = job_id_q;
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = OUT;
        end
      end
      SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          res_id_d   = job_id_q;
          res_data_d = mult_in;
          res_err_d  = 1'b0;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          job_ready = 1'b1;
          // Accept the next job in the same cycle as the result handshake.
          if (job_valid) begin
            job_id_d = job_id;
            start_d  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(TMO_CYC);
            state_d  = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      job_id_q   <= '0;
      res_id_q   <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      job_id_q   <= job_id_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      start_q    <= start_d;
    end
  end

  assign tlut_start = start_q;
  assign res_valid  = (state_q == OUT);
  assign res_id     = res_id_q;
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;

`ifdef TLUT_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_jobs_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_jobs_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if ((state_q == OUT) && res_ready) perf_jobs_q <= perf_jobs_q + PERF_W'(1);
      if ((state_q == OUT) && !res_ready) perf_stall_q <= perf_stall_q + PERF_W'(1);
    end
  end

  assign perf_jobs  = perf_jobs_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_tlut_mul_sched.sv
// Scoreboard bench for tlut_mul_sched. The driver pushes the expected result
// when it offers a job. The monitor pops and compares on every result handshake.
module tb_tlut_mul_sched;

  localparam int unsigned ID_W     = 4;
  localparam int unsigned RES_W    = 144;
  localparam int unsigned TREE_LAT = 1;
  localparam int unsigned TMO_CYC  = 8;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [RES_W-1:0] data;
    logic             err;
  } exp_t;

  localparam logic [RES_W-1:0] D1 = {16'hBEEF, 120'h0, 8'hA5};
  localparam logic [RES_W-1:0] D2 = {8'h11, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 8'h3C};
  localparam logic [RES_W-1:0] D3 = {136'hC0FFEE, 8'h5A};

  logic             clk = 1'b0;
  logic             rst, job_valid, job_ready, tlut_start, tlut_done;
  logic             res_valid, res_ready, res_err;
  logic [ID_W-1:0]  job_id, res_id;
  logic [RES_W-1:0] mult_in, res_data;
`ifdef TLUT_SCHED_PERF_EN
  logic [31:0]      perf_jobs, perf_stall;
`endif

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tlut_mul_sched #(
    .ID_W     (ID_W),
    .RES_W    (RES_W),
    .TREE_LAT (TREE_LAT),
    .TMO_CYC  (TMO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_id     (job_id),
    .tlut_start (tlut_start),
    .tlut_done  (tlut_done),
    .mult_in    (mult_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_data   (res_data),
    .res_err    (res_err)
`ifdef TLUT_SCHED_PERF_EN
    ,
    .perf_jobs  (perf_jobs),
    .perf_stall (perf_stall)
`endif
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input logic [ID_W-1:0] act, input logic [ID_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [RES_W-1:0] act,
                      input logic [RES_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for res_valid, then let the handshake edge pass.
  task automatic wait_result(input string nm, input int max_cyc);
    int i = 0;
    @(negedge clk);
    while (!res_valid && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    chk1(nm, res_valid, 1'b1);
    drv();
  endtask

  task automatic chk_reset_outs(input string nm);
    chk1({nm, "_job_ready"}, job_ready, 1'b1);
    chk1({nm, "_tlut_start"}, tlut_start, 1'b0);
    chk1({nm, "_res_valid"}, res_valid, 1'b0);
    chki({nm, "_res_id"}, res_id, '0);
    chkw({nm, "_res_data"}, res_data, '0);
    chk1({nm, "_res_err"}, res_err, 1'b0);
  endtask

  // Monitor: compare every presented-and-accepted result against the scoreboard.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got id %0d, required no result", res_id);
      end else begin
        mon_e = sb.pop_front();
        chki("res_id", res_id, mon_e.id);
        chkw("res_data", res_data, mon_e.data);
        chk1("res_err", res_err, mon_e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_id = '0; tlut_done = 1'b0; mult_in = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst");

    // Single job id 3: done 5 cycles after start, then a 10-cycle stall.
    drv(); rst = 1'b0; job_valid = 1'b1; job_id = 4'd3; mult_in = D1;
    sb.push_back('{id: 4'd3, data: D1, err: 1'b0});
    @(negedge clk); chk1("idle_job_ready", job_ready, 1'b1);
    drv(); job_valid = 1'b0; job_id = '0;
    @(negedge clk); chk1("start_pulse", tlut_start, 1'b1); chk1("run_job_ready", job_ready, 1'b0);
    drv();
    @(negedge clk); chk1("start_single", tlut_start, 1'b0);
    repeat (4) drv();
    tlut_done = 1'b1;
    drv(); tlut_done = 1'b0;
    @(negedge clk); chk1("settle_no_valid", res_valid, 1'b0);
    drv();
    @(negedge clk); chk1("capture_no_valid", res_valid, 1'b0);
    drv(); mult_in = D3; job_valid = 1'b1; job_id = 4'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("stall_valid", res_valid, 1'b1);
      chkw("stall_data", res_data, D1);
      chk1("stall_job_ready", job_ready, 1'b0);
      if (i < 9) drv();
    end
    drv(); job_valid = 1'b0; job_id = '0; res_ready = 1'b1;
`ifdef TLUT_SCHED_PERF_EN
    @(negedge clk); chkw("perf_stall", RES_W'(perf_stall), RES_W'(10));
`endif
    drv();

    // Back-to-back: job 2 accepted in job 1's result handshake cycle.
    job_valid = 1'b1; job_id = 4'd1; mult_in = D2;
    sb.push_back('{id: 4'd1, data: D2, err: 1'b0});
    @(negedge clk); chk1("idle_after_hs", job_ready, 1'b1); chk1("idle_no_valid", res_valid, 1'b0);
    drv(); job_id = 4'd2;
    drv(); tlut_done = 1'b1;
    drv(); tlut_done = 1'b0;
    drv();
    drv(); mult_in = D3;
    sb.push_back('{id: 4'd2, data: D3, err: 1'b0});
    @(negedge clk); chk1("b2b_valid", res_valid, 1'b1); chk1("b2b_job_ready", job_ready, 1'b1);
    drv(); job_valid = 1'b0; job_id = '0;
    @(negedge clk); chk1("b2b_start", tlut_start, 1'b1); chk1("b2b_no_idle", job_ready, 1'b0);
    drv(); tlut_done = 1'b1;
    drv(); tlut_done = 1'b0;
    wait_result("job2_result", 10);

    // Reset during SETTLE drops the job.
    job_valid = 1'b1; job_id = 4'd7;
    drv(); job_valid = 1'b0; job_id = '0;
    drv(); tlut_done = 1'b1;
    drv(); tlut_done = 1'b0; rst = 1'b1;
    @(negedge clk); chk_reset_outs("mid_rst");
    drv(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); chk1("rst_dropped", res_valid, 1'b0);
      drv();
    end

    // Timeout: no tlut_done, result after exactly TMO_CYC RUN cycles.
    job_valid = 1'b1; job_id = 4'd5; mult_in = D1; res_ready = 1'b0;
    sb.push_back('{id: 4'd5, data: '0, err: 1'b1});
    drv(); job_valid = 1'b0; job_id = '0;
    @(negedge clk); chk1("tmo_start", tlut_start, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drv();
      @(negedge clk); chk1("tmo_wait", res_valid, 1'b0);
    end
    drv();
    @(negedge clk); chk1("tmo_expire", res_valid, 1'b1);
    drv(); res_ready = 1'b1;
    drv();

    // tlut_done only in the start-pulse cycle is ignored, so the job times out.
    job_valid = 1'b1; job_id = 4'd6;
    sb.push_back('{id: 4'd6, data: '0, err: 1'b1});
    drv(); job_valid = 1'b0; job_id = '0; tlut_done = 1'b1;
    @(negedge clk); chk1("ign_start", tlut_start, 1'b1);
    drv(); tlut_done = 1'b0;
    wait_result("ign_done_timeout", 12);
    drv();

`ifdef TLUT_SCHED_PERF_EN
    @(negedge clk); chkw("perf_jobs", RES_W'(perf_jobs), RES_W'(5));
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_empty: %0d results outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
